physics_frame_scheduler: RTL and testbench
==========================================

# physics_frame_scheduler

Once per video frame, this block runs the game-physics update as a fixed, ordered series of step strobes. It triggers on the start of vertical blanking. A valid/done handshake with the physics datapath gates each step, so the datapath never moves player or ball state while pixels are being drawn. The block replaces the free-running idle counter. It sits between the VGA sync generator and the physics register file.

## Interface
- STEP_TIMEOUT, 255: maximum cycles `step_valid` may be held for one step before that step is force-completed.
- GRAV_DIV, 6: frame divider for gravity/vertical steps. Vertical steps run on every GRAV_DIV-th accepted frame.
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- enable  in  1  1 = accept new frames; a frame already in progress always completes
- vblank_start  in  1  one-cycle pulse at the start of vertical blanking, already synchronous to clk
- step_done  in  1  datapath has completed the step currently presented
- step_valid  out  1  a step is being presented to the datapath
- step_id  out  3  step code: 0 VEL_X, 1 VEL_Y, 2 BALL_VEL, 3 POS_X, 4 POS_Y, 5 BALL_POS, 6 FIX_X, 7 FIX_Y
- grav_en  out  1  current frame includes the vertical steps; held constant for the whole frame
- busy  out  1  a frame update is in progress; the renderer must not sample physics state
- frame_cnt  out  16  count of completed frames
- overrun  out  1  one-cycle pulse: vblank_start arrived while busy
- timeout_err  out  1  sticky; set when any step is force-completed

## Operation
- States:
  - IDLE: waits for a frame trigger.
  - RUN: presents step_id with step_valid=1.
  - FINISH: a single cycle that increments frame_cnt.
- IDLE -> RUN when vblank_start=1 and enable=1. On that edge:
  - grav_en <= (phase == GRAV_DIV-1).
  - phase <= phase == GRAV_DIV-1 ? 0 : phase+1.
  - step_id <= 0.
- vblank_start while enable=0 is ignored: no frame, no phase change, no overrun.
- Step sequence:
  - grav_en=1: 0,1,2,3,4,5,6,7.
  - grav_en=0: 0,3,6. Steps 1,2,4,5,7 are skipped and never presented.
- Handshake:
  - step_id is stable while step_valid=1.
  - A step completes on an edge where step_valid=1 and step_done=1.
  - step_done while step_valid=0 is ignored.
- Wait counter (8 bits minimum):
  - Cleared when each step is presented.
  - Increments each cycle with step_valid=1 and step_done=0.
  - If wait==STEP_TIMEOUT-1 and step_done=0, the step is force-completed on that edge and timeout_err is set. step_valid is therefore high for at most STEP_TIMEOUT cycles per step.
- After the last step completes, the next state is FINISH: step_valid=0, busy=1, frame_cnt increments (wraps 65535 -> 0). Then IDLE.
- vblank_start while busy=1 (RUN or FINISH) is dropped and produces overrun=1 for exactly one cycle. This includes the cycle in which the last step completes.
- Deasserting enable mid-frame does not abort the frame.
- Reset:
  - Values: step_valid 0, step_id 0, grav_en 0, busy 0, frame_cnt 0, overrun 0, timeout_err 0, phase 0, state IDLE.
  - Reset mid-frame aborts at once; no further strobes are issued.

## Timing
- Trigger edge T (vblank_start=1 in IDLE): at T+1, busy=1, step_valid=1, step_id=0.
- Back-to-back steps: if step_done=1 in the same cycle as step_valid, the next step_id appears the following cycle. One cycle per step minimum.
- Minimum busy duration:
  - grav_en=1 frame: 9 cycles (8 steps + FINISH).
  - grav_en=0 frame: 4 cycles (3 steps + FINISH).
- frame_cnt becomes visible in the cycle after FINISH, coincident with busy=0.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
1. Rhythm: GRAV_DIV=6, step_done tied 1, six vblank pulses spaced 20 cycles apart.
   - Frames 1-5: ids 0,3,6 with grav_en=0; busy high 4 cycles each.
   - Frame 6: ids 0..7 with grav_en=1; busy high 9 cycles.
   - frame_cnt=6 at the end.
2. Slow done: step_done asserted 3 cycles after each step_valid rise.
   - Each step_id is held exactly 4 cycles.
   - No timeout_err.
3. Timeout: STEP_TIMEOUT=16, step_done held 0, grav_en=0 frame.
   - Each step is valid exactly 16 cycles; steps 0,3,6 are all issued.
   - timeout_err=1 from the first forced edge onward.
   - frame_cnt=1 after 49 busy cycles.
4. Overrun: vblank_start during step 3 of a frame.
   - overrun high 1 cycle.
   - The frame completes normally; frame_cnt +1 only.
   - The next frame's grav_en matches a sequence with the dropped pulse removed.
5. Enable and reset:
   - enable=0 plus vblank_start: busy stays 0 and frame_cnt is unchanged.
   - reset_n=0 while step_id=4: the next cycle shows all outputs at reset values, and no strobe follows after release until a new vblank_start.
6. Wrap: 65536 frames with step_done tied 1 -> frame_cnt returns to 0 with no other anomaly.

Source files
------------

// File: rtl/physics_frame_scheduler_if.sv
// Step handshake between the frame scheduler and the physics datapath.
// The scheduler presents step_id/grav_en with step_valid; the datapath answers with step_done.
interface physics_frame_scheduler_if;
  logic       step_valid;
  logic [2:0] step_id;
  logic       grav_en;
  logic       step_done;

  modport master (output step_valid, output step_id, output grav_en, input step_done);
  modport slave  (input step_valid, input step_id, input grav_en, output step_done);
endinterface

// File: rtl/physics_frame_scheduler.sv
// Per-frame physics update sequencer, triggered by vblank_start.
// Issues an ordered series of step strobes to the physics datapath, gated by a
// valid/done handshake with a per-step timeout. Vertical steps run only on every
// GRAV_DIV-th accepted frame.
//
// state  | meaning
// IDLE   | waiting for vblank_start with enable=1
// RUN    | presenting step_id with step_valid=1
// FINISH | one cycle, frame_cnt increments, busy still high
module physics_frame_scheduler #(
  parameter int STEP_TIMEOUT = 255,
  parameter int GRAV_DIV     = 6
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic                             vblank_start,
  physics_frame_scheduler_if.master        step_bus,
  output logic                             busy,
  output logic [15:0]                      frame_cnt,
  output logic                             overrun,
  output logic                             timeout_err
);

  localparam int WAIT_W = ($clog2(STEP_TIMEOUT) > 8) ? $clog2(STEP_TIMEOUT) : 8;
  localparam int PH_W   = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t              state_q, state_n;
  logic                valid_q, valid_n;
  logic [2:0]          id_q, id_n;
  logic                grav_q, grav_n;
  logic                busy_q, busy_n;
  logic [15:0]         cnt_q, cnt_n;
  logic                ovr_q, ovr_n;
  logic                to_q, to_n;
  logic [PH_W-1:0]     phase_q, phase_n;
  logic [WAIT_W-1:0]   wait_q, wait_n;

  logic                last_step;
  logic                forced;

  assign step_bus.step_valid = valid_q;
  assign step_bus.step_id    = id_q;
  assign step_bus.grav_en    = grav_q;
  assign busy                = busy_q;
  assign frame_cnt           = cnt_q;
  assign overrun             = ovr_q;
  assign timeout_err         = to_q;

  // Register all state and outputs; synchronous active-low reset aborts any frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      id_q    <= 3'd0;
      grav_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 16'd0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
      phase_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_n;
      valid_q <= valid_n;
      id_q    <= id_n;
      grav_q  <= grav_n;
      busy_q  <= busy_n;
      cnt_q   <= cnt_n;
      ovr_q   <= ovr_n;
      to_q    <= to_n;
      phase_q <= phase_n;
      wait_q  <= wait_n;
    end
  end

  // Next-state and next-output logic; the step order skips vertical steps when grav_en=0.
  always_comb begin
    state_n   = state_q;
    valid_n   = valid_q;
    id_n      = id_q;
    grav_n    = grav_q;
    busy_n    = busy_q;
    cnt_n     = cnt_q;
    ovr_n     = 1'b0;
    to_n      = to_q;
    phase_n   = phase_q;
    wait_n    = wait_q;
    last_step = grav_q ? (id_q == 3'd7) : (id_q == 3'd6);
    forced    = (wait_q == WAIT_W'(STEP_TIMEOUT - 1)) && !step_bus.step_done;

    unique case (state_q)
      IDLE: begin
        if (vblank_start && enable) begin
          state_n = RUN;
          grav_n  = (phase_q == PH_W'(GRAV_DIV - 1));
          phase_n = (phase_q == PH_W'(GRAV_DIV - 1)) ? '0 : phase_q + 1'b1;
          id_n    = 3'd0;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          wait_n  = '0;
        end
      end
      RUN: begin
        ovr_n = vblank_start;
        if (step_bus.step_done || forced) begin
          if (forced) to_n = 1'b1;
          wait_n = '0;
          if (last_step) begin
            state_n = FINISH;
            valid_n = 1'b0;
          end else begin
            id_n = grav_q ? id_q + 3'd1 : id_q + 3'd3;
          end
        end else begin
          wait_n = wait_q + 1'b1;
        end
      end
      FINISH: begin
        ovr_n   = vblank_start;
        cnt_n   = cnt_q + 16'd1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_physics_frame_scheduler.sv
// Self-checking bench for physics_frame_scheduler (STEP_TIMEOUT shortened to 16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_physics_frame_scheduler;
  localparam int TO = 16;
  localparam int GD = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        vblank_start = 1'b0;
  logic        busy;
  logic        overrun;
  logic        timeout_err;
  logic [15:0] frame_cnt;

  physics_frame_scheduler_if bus ();

  physics_frame_scheduler #(.STEP_TIMEOUT(TO), .GRAV_DIV(GD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .vblank_start (vblank_start),
    .step_bus     (bus.master),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          acc = 0;          // accepted frames since reset (reference phase)
  logic [15:0] exp_cnt = 16'd0;
  logic        exp_to = 1'b0;
  int          blen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Tick inside a frame: a vblank driven while busy must show up as a one-cycle overrun.
  task automatic ftick();
    logic ov_exp;
    ov_exp = vblank_start;
    if (busy === 1'b1) blen++;
    tick();
    chk("overrun", overrun, ov_exp);
    vblank_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_valid", bus.step_valid, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  // One frame: d = step_done delay per step in [dmin,dmax]; ov_id = step id to inject
  // a vblank on (8 = FINISH cycle, -1 = none).
  task automatic do_frame(input int dmin, input int dmax, input int ov_id);
    logic g;
    int   seq[$];
    int   d;
    int   hold;
    int   total;
    g = ((acc % GD) == GD - 1);
    acc++;
    if (g) seq = '{0, 1, 2, 3, 4, 5, 6, 7};
    else   seq = '{0, 3, 6};
    blen  = 0;
    total = 1;
    enable = 1'b1;
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    chk("trig_busy", busy, 1);
    chk("trig_grav", bus.grav_en, g);
    chk("trig_overrun", overrun, 0);
    foreach (seq[k]) begin
      d = int'($urandom_range(dmax, dmin));
      hold = (d + 1 < TO) ? d + 1 : TO;
      total += hold;
      for (int c = 0; c < hold; c++) begin
        chk("valid", bus.step_valid, 1);
        chk("step_id", bus.step_id, seq[k]);
        chk("grav_hold", bus.grav_en, g);
        if (c == 0 && seq[k] == ov_id) vblank_start = 1'b1;
        bus.step_done = (c == d);
        ftick();
        bus.step_done = 1'b0;
      end
      if (d >= TO) exp_to = 1'b1;
      chk("timeout_err", timeout_err, exp_to);
    end
    chk("fin_valid", bus.step_valid, 0);
    chk("fin_busy", busy, 1);
    chk("fin_cnt", frame_cnt, exp_cnt);
    if (ov_id == 8) vblank_start = 1'b1;
    ftick();
    exp_cnt++;
    chk("done_busy", busy, 0);
    chk("frame_cnt", frame_cnt, exp_cnt);
    chk("busy_len", blen, total);
  endtask

  task automatic chk_reset_vals();
    chk("rst_valid", bus.step_valid, 0);
    chk("rst_id", bus.step_id, 0);
    chk("rst_grav", bus.grav_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout_err, 0);
  endtask

  initial begin
    int  ov;
    int  dm;
    logic found;
    bus.step_done = 1'b0;

    // reset values
    repeat (3) tick();
    chk_reset_vals();
    reset_n = 1'b1;
    idle(2);

    // rhythm: five plain frames then one gravity frame, step_done immediate
    for (int f = 0; f < 6; f++) begin
      do_frame(0, 0, -1);
      idle(12);
    end
    chk("rhythm_cnt", frame_cnt, 6);

    // slow done: each step held exactly 4 cycles
    do_frame(3, 3, -1);
    idle(4);

    // timeout: every step forced after TO cycles, 49 busy cycles
    do_frame(100, 100, -1);
    idle(4);

    // overrun during step 3; the dropped pulse must not advance the phase
    do_frame(0, 2, 3);
    idle(4);
    do_frame(0, 0, 8);
    idle(4);

    // enable low: vblank ignored
    enable = 1'b0;
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    chk("en0_busy", busy, 0);
    chk("en0_valid", bus.step_valid, 0);
    chk("en0_overrun", overrun, 0);
    idle(3);
    chk("en0_cnt", frame_cnt, exp_cnt);
    enable = 1'b1;

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      ov = ($urandom_range(3, 0) == 0) ? int'($urandom_range(8, 0)) : -1;
      dm = ($urandom_range(4, 0) == 0) ? 20 : 4;
      do_frame(0, dm, ov);
      idle(int'($urandom_range(5, 1)));
    end

    // reset while step_id=4 in a gravity frame
    while ((acc % GD) != GD - 1) begin
      do_frame(0, 1, -1);
      idle(2);
    end
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    bus.step_done = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (bus.step_valid === 1'b1 && bus.step_id === 3'd4) found = 1'b1;
      else tick();
    end
    chk("reach_id4", found, 1);
    reset_n = 1'b0;
    bus.step_done = 1'b0;
    tick();
    chk_reset_vals();
    reset_n = 1'b1;
    acc = 0;
    exp_cnt = 16'd0;
    exp_to = 1'b0;
    idle(10);
    do_frame(0, 0, -1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
